// File: rtl/hex_scan_driver.sv
// Four-digit seven-segment scan driver: multiplexes per-digit segment patterns onto a
// shared bus with a dead-time gap at each digit change and optional per-digit blinking.
module hex_scan_driver #(
    parameter int         CLOCK_HZ     = 50000000,
    parameter int         SCAN_HZ      = 4000,
    parameter int         BLANK_CYCLES = 2,
    parameter int         BLINK_FRAMES = 250,
    parameter logic [7:0] SEG_OFF      = 8'hFF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [0:3][7:0] hex,
    input  logic [3:0]      blink_mask,
    output logic [7:0]      seg,
    output logic [3:0]      dig_sel,
    output logic            frame_done
);

    localparam int SLOT_CYCLES = CLOCK_HZ / SCAN_HZ;
    localparam int P_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int F_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [P_W-1:0] P_LAST  = P_W'(SLOT_CYCLES - 1);
    localparam logic [P_W-1:0] P_BLANK = P_W'(BLANK_CYCLES);
    localparam logic [F_W-1:0] F_LAST  = F_W'(BLINK_FRAMES - 1);

    generate
        if (SLOT_CYCLES < BLANK_CYCLES + 1) begin : g_bad_slot
            $fatal(1, "hex_scan_driver: slot too short for the dead-time gap");
        end
        if (BLINK_FRAMES < 1) begin : g_bad_blink
            $fatal(1, "hex_scan_driver: BLINK_FRAMES must be at least 1");
        end
    endgenerate

    typedef enum logic {BLANK, DRIVE} slot_state_t;
    localparam slot_state_t STATE_RST = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

    slot_state_t    state_reg, state_next;
    logic [P_W-1:0] p_reg, p_next;
    logic [1:0]     d_reg, d_next;
    logic [F_W-1:0] f_reg, f_next;
    logic           blink_on_reg, blink_on_next;
    logic [7:0]     snap_hex_reg [0:3];
    logic [3:0]     snap_mask_reg;
    logic           snap_en;
    logic           frame_end;
    logic [7:0]     seg_next;
    logic [3:0]     dig_sel_next;
    logic [3:0]     dig_sel_drive;

    // State register: scan position, blink timing and the frame snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= STATE_RST;
            p_reg         <= '0;
            d_reg         <= '0;
            f_reg         <= '0;
            blink_on_reg  <= 1'b1;
            snap_mask_reg <= '0;
            for (int i = 0; i < 4; i++) begin
                snap_hex_reg[i] <= SEG_OFF;
            end
        end else begin
            state_reg    <= state_next;
            p_reg        <= p_next;
            d_reg        <= d_next;
            f_reg        <= f_next;
            blink_on_reg <= blink_on_next;
            if (snap_en) begin
                snap_mask_reg <= blink_mask;
                for (int i = 0; i < 4; i++) begin
                    snap_hex_reg[i] <= hex[i];
                end
            end
        end
    end

    // Next-state logic. The frame counter advances on the last cycle of each frame so the
    // blink toggle lands exactly on the following frame boundary.
    always_comb begin
        p_next        = p_reg + 1'b1;
        d_next        = d_reg;
        f_next        = f_reg;
        blink_on_next = blink_on_reg;
        snap_en       = (d_reg == 2'd0) && (p_reg == '0);
        frame_end     = (d_reg == 2'd3) && (p_reg == P_LAST);
        if (p_reg == P_LAST) begin
            p_next = '0;
            d_next = d_reg + 2'd1;
        end
        if (frame_end) begin
            if (f_reg == F_LAST) begin
                f_next        = '0;
                blink_on_next = !blink_on_reg;
            end else begin
                f_next = f_reg + 1'b1;
            end
        end
        state_next = (p_next < P_BLANK) ? BLANK : DRIVE;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dig
            assign dig_sel_drive[gi] = (d_reg != 2'(gi));
        end
    endgenerate

    // Output logic; the enable stays on during blink-off so brightness duty is unchanged.
    always_comb begin
        seg_next     = SEG_OFF;
        dig_sel_next = 4'b1111;
        if (state_reg == DRIVE) begin
            dig_sel_next = dig_sel_drive;
            if (!(snap_mask_reg[d_reg] && !blink_on_reg)) begin
                seg_next = snap_hex_reg[d_reg];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg        <= SEG_OFF;
            dig_sel    <= 4'b1111;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next;
            dig_sel    <= dig_sel_next;
            frame_done <= frame_end;
        end
    end

endmodule
